uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter among `n_req` message sources. Each source streams bytes with a valid/ready/last handshake. Once a source is granted, it owns the transmitter for its whole message, so messages never interleave. After each message the block inserts a fixed idle gap, then re-arbitrates. It sits between the on-chip message producers and the UART's byte-level start/busy interface.

## Interface
- `n_req`, default 4: number of requesters, range 2..8.
- `gap_cycles`, default 16: idle clock cycles inserted after each message's final byte; 0 means no gap.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  n_req  bit i: requester i presents a byte.
- `req_data`  in  8*n_req  byte of requester i at bits [8i+7:8i].
- `req_last`  in  n_req  bit i: the presented byte is the final byte of the message.
- `req_ready`  out  n_req  bit i: byte of requester i accepted this cycle. Combinational.
- `grant`  out  n_req  one-hot current owner; all zero when no owner. Registered.
- `uart_data`  out  8  byte to transmit. Registered.
- `uart_start`  out  1  single-cycle pulse that launches `uart_data`. Registered.
- `uart_busy`  in  1  UART is serialising a byte.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**
  - `grant` = 0.
  - If any `req_valid` bit is set, select the first set bit, scanning cyclically from `ptr`.
  - Load `grant` with the one-hot selection, set `ptr` = winner+1 mod `n_req`, go to SEND.
  - After reset `ptr` = 0.
- **SEND**
  - `req_ready[i]` = (state==SEND) & `grant[i]` & `req_valid[i]` & !`uart_busy`. All other bits of `req_ready` are 0.
  - On handshake:
    - `uart_data` <= byte of the owner.
    - `uart_start` <= 1 for exactly one cycle.
    - `last_q` <= `req_last` of the owner.
    - Go to WAIT_BUSY.
  - If the owner drops `req_valid`, stay in SEND indefinitely with `grant` held. Other requesters are never served mid-message.
- **WAIT_BUSY**: stay until `uart_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE**: stay until `uart_busy`=0.
  - If `last_q`=0, return to SEND.
  - If `last_q`=1 and `gap_cycles`>0, clear `grant`, load the gap counter with `gap_cycles`-1, go to GAP.
  - If `last_q`=1 and `gap_cycles`=0, clear `grant`, go directly to IDLE.
- **GAP**: decrement the counter each cycle. When it reaches 0, go to IDLE. `req_ready` = 0 throughout.
- Width rules:
  - The gap counter is $clog2(gap_cycles+1) bits.
  - `ptr` is $clog2(n_req) bits and wraps from `n_req`-1 to 0.
- Reset value of every output:
  - `grant` = 0, `uart_data` = 0x00, `uart_start` = 0, `req_ready` = 0.
  - Internal: state = IDLE, `ptr` = 0, `last_q` = 0, gap counter = 0.
  - Reset asserted mid-message aborts immediately. No further `uart_start` is issued, and the partially accepted message is not resumed.
- A requester whose `req_valid` is high in IDLE but loses arbitration waits. It is guaranteed service within `n_req`-1 messages.

## Timing
- Arbitration: `req_valid` first seen in IDLE at cycle t gives `grant` valid at t+1 (SEND).
- If `uart_busy`=0 at t+1, `req_ready` is high at t+1 and `uart_start` pulses at t+2.
- Handshake to `uart_start`: 1 cycle. `uart_data` is stable from the `uart_start` cycle until the next handshake.
- Between bytes of one message: the next handshake occurs no earlier than the first cycle after `uart_busy` falls.
- Message end to next grant: `uart_busy` falls at cycle f; the gap covers cycles f+1..f+`gap_cycles`; IDLE is at f+`gap_cycles`+1; `grant` is at f+`gap_cycles`+2.
- With `gap_cycles`=0: IDLE at f+1, `grant` at f+2.
- If `uart_busy` is already high on entry to SEND (e.g. a UART shared with other logic), the handshake is withheld until it falls.
- Bytes are never dropped or duplicated. Exactly one `uart_start` pulse is issued per accepted byte.

## Test plan
- **Single requester**
  - Stimulus: `n_req`=4; requester 2 sends 0x41, 0x42, 0x43 (last on 0x43); UART model raises busy 1 cycle after start for 10 cycles.
  - Required: `grant`=0b0100; three `uart_start` pulses carrying 0x41, 0x42, 0x43 in order; `grant`=0 after the final busy fall; GAP lasts exactly 16 cycles.
- **Round-robin fairness**
  - Stimulus: all four requesters hold 1-byte messages 0x10, 0x11, 0x12, 0x13 from reset.
  - Required: service order is 0, 1, 2, 3. With requesters 0 and 3 immediately re-requesting after 1, 2, 3 are served, the order continues 0, 3, 0, 3.
- **No interleave**
  - Stimulus: requester 1 sends a 4-byte message and deasserts `req_valid` for 20 cycles after byte 2; requester 0 is valid throughout.
  - Required: `grant` holds 0b0010; `req_ready[0]` stays 0; requester 0 is granted only after requester 1's last byte plus the gap.
- **Zero gap**
  - Stimulus: `gap_cycles`=0; back-to-back 1-byte messages from requesters 0 and 1.
  - Required: `grant`=0b0010 exactly 2 cycles after busy falls.
- **Reset mid-message**
  - Stimulus: assert `reset` low while in WAIT_DONE of byte 2 of 5.
  - Required: `grant`, `uart_start`, `req_ready` go to 0 and `uart_data` to 0x00 asynchronously. After release, arbitration restarts with `ptr`=0 and no stale start pulse.
- **Busy at entry**
  - Stimulus: `uart_busy` held high 8 cycles when SEND is entered.
  - Required: `req_ready` stays 0 for those 8 cycles; the handshake occurs on the first cycle busy is low; `uart_start` follows 1 cycle later.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Byte-stream handshake bundle between the message producers
//               and the UART transmit arbiter (valid/ready/last per source).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;

    // Producer side: drives bytes, observes acceptance
    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    // Arbiter side: observes bytes, signals acceptance
    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin scheduler sharing one UART byte transmitter among
//               N_REQ message sources. A granted source owns the UART for its
//               whole message; a fixed idle gap follows every message.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  req,
    output logic [N_REQ-1:0]  grant,
    output logic [7:0]        uart_data,
    output logic              uart_start,
    input  logic              uart_busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [7:0]         data_nxt;
    logic               start_nxt;
    logic               last_q;
    logic               last_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   cand;
    logic [N_REQ-1:0]   arb_onehot;
    logic [7:0]         owner_data;
    logic               owner_last;
    logic               handshake;

    // Only the owner may hand over a byte, and only while the UART is free
    assign req.req_ready = (state == S_SEND && !uart_busy) ? (grant & req.req_valid) : '0;
    assign handshake     = |req.req_ready;

    // Cyclic priority scan starting at ptr; first valid requester wins
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!arb_found && req.req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        arb_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
    end

    // Select the byte and last flag of the current owner
    always_comb begin
        owner_data = 8'h00;
        owner_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_data = req.req_data[8*i +: 8];
                owner_last = req.req_last[i];
            end
        end
    end

    // Next-state and next-output logic of the message scheduler
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        data_nxt  = uart_data;
        start_nxt = 1'b0;
        last_nxt  = last_q;
        gap_nxt   = gap_cnt;
        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_onehot;
                    ptr_nxt   = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // Owner stalling keeps the grant; nobody else is served mid-message
                if (handshake) begin
                    data_nxt  = owner_data;
                    start_nxt = 1'b1;
                    last_nxt  = owner_last;
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (!last_q) begin
                        state_nxt = S_SEND;
                    end else if (GAP_CYCLES > 0) begin
                        grant_nxt = '0;
                        gap_nxt   = GAP_LOAD;
                        state_nxt = S_GAP;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any message in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            grant      <= '0;
            uart_data  <= 8'h00;
            uart_start <= 1'b0;
            last_q     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            grant      <= grant_nxt;
            uart_data  <= data_nxt;
            uart_start <= start_nxt;
            last_q     <= last_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter: a byte scoreboard
//               fed by the requester drivers and drained by the start monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int GAP      = 16;
    localparam int BUSY_LEN = 10;
    localparam int TMO      = 600;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] grant0;
    logic [3:0] grant1;
    logic [7:0] uart_data0;
    logic [7:0] uart_data1;
    logic       uart_start0;
    logic       uart_start1;
    logic       model_busy0;
    logic       model_busy1;
    logic       ext_busy0;
    logic       uart_busy0;
    logic       uart_busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall0_cyc = 0;
    int fall1_cyc = 0;
    int grant_rise_cyc = 0;
    int start_cnt0 = 0;
    bit abort = 0;

    exp_t sb [$];
    int   order_q [$];

    uart_tx_arbiter_if #(.N_REQ(4)) bus0 ();
    uart_tx_arbiter_if #(.N_REQ(4)) bus1 ();

    assign uart_busy0 = model_busy0 | ext_busy0;
    assign uart_busy1 = model_busy1;

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .req        (bus0),
        .grant      (grant0),
        .uart_data  (uart_data0),
        .uart_start (uart_start0),
        .uart_busy  (uart_busy0)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) dut_nogap (
        .clk        (clk),
        .reset      (reset_n),
        .req        (bus1),
        .grant      (grant1),
        .uart_data  (uart_data1),
        .uart_start (uart_start1),
        .uart_busy  (uart_busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART model: busy rises one cycle after a start pulse and lasts BUSY_LEN cycles
    initial begin
        int  cnt;
        bit  pend;
        cnt = 0; pend = 0; model_busy0 = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin model_busy0 = 1'b0; fall0_cyc = cyc; end
            end else if (pend) begin
                pend = 0; model_busy0 = 1'b1; cnt = BUSY_LEN;
            end
            if (uart_start0 === 1'b1) pend = 1;
        end
    end

    initial begin
        int  cnt;
        bit  pend;
        cnt = 0; pend = 0; model_busy1 = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin model_busy1 = 1'b0; fall1_cyc = cyc; end
            end else if (pend) begin
                pend = 0; model_busy1 = 1'b1; cnt = BUSY_LEN;
            end
            if (uart_start1 === 1'b1) pend = 1;
        end
    end

    // Start monitor: every pulse must match the oldest accepted byte
    initial begin
        exp_t       e;
        logic [3:0] oh;
        logic       prev_start;
        logic [3:0] prev_grant;
        prev_start = 1'b0;
        prev_grant = 4'b0;
        forever begin
            @(negedge clk);
            if (prev_grant === 4'b0 && grant0 !== 4'b0 && grant0 !== 4'bx) grant_rise_cyc = cyc;
            if (uart_start0 === 1'b1) begin
                start_cnt0++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: data=%h grant=%b, required no start pulse", uart_data0, grant0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.idx;
                    order_q.push_back(e.idx);
                    if (uart_data0 !== e.data || grant0 !== oh || cyc != e.cyc + 1) begin
                        errors++;
                        $display("FAIL start_match: data=%h grant=%b cyc=%0d, required data=%h grant=%b cyc=%0d",
                                 uart_data0, grant0, cyc, e.data, oh, e.cyc + 1);
                    end
                end
                checks++;
                if (prev_start === 1'b1) begin
                    errors++;
                    $display("FAIL start_width: start high two cycles in a row, required single-cycle pulse");
                end
            end
            prev_start = uart_start0;
            prev_grant = grant0;
        end
    end

    task automatic send_msg(input int idx, input byte_q_t bytes, input int pause_after, input int pause_len);
        exp_t       e;
        logic [3:0] oh;
        logic       bad;
        bit         done;
        int         t;
        oh = 4'b0001 << idx;
        for (int k = 0; k < bytes.size(); k++) begin
            if (abort) break;
            bus0.req_data[idx*8 +: 8] = bytes[k];
            bus0.req_last[idx]        = (k == bytes.size() - 1);
            bus0.req_valid[idx]       = 1'b1;
            done = 0;
            t    = 0;
            while (!done && !abort) begin
                #1;
                if (bus0.req_ready[idx] === 1'b1) begin
                    e.idx = idx; e.data = bytes[k]; e.cyc = cyc;
                    sb.push_back(e);
                    done = 1;
                end
                @(negedge clk);
                t++;
                if (!done && t > TMO) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: req=%0d byte=%h ready never seen, required a handshake", idx, bytes[k]);
                    bus0.req_valid[idx] = 1'b0;
                    return;
                end
            end
            bus0.req_valid[idx] = 1'b0;
            if (pause_len > 0 && k + 1 == pause_after) begin
                bad = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    #1;
                    if (grant0 !== oh || bus0.req_ready !== 4'b0) bad = 1'b1;
                    @(negedge clk);
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL pause_hold: grant=%b ready=%b, required grant=%b ready=0000", grant0, bus0.req_ready, oh);
                end
            end
        end
        bus0.req_last[idx] = 1'b0;
    endtask

    task automatic wait_quiet();
        int c;
        c = 0;
        @(negedge clk);
        while ((grant0 !== 4'b0 || uart_busy0 !== 1'b0) && c < TMO) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= TMO) begin
            errors++;
            $display("FAIL wait_quiet: grant=%b busy=%b, required grant=0000 busy=0", grant0, uart_busy0);
        end
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        bus0.req_valid = 4'b1111;
        bus0.req_last  = 4'b1111;
        bus0.req_data  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (grant0 !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant0); end
        checks++;
        if (uart_start0 !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", uart_start0); end
        checks++;
        if (uart_data0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", uart_data0); end
        checks++;
        if (bus0.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", bus0.req_ready); end
        @(negedge clk);
        bus0.req_valid = 4'b0;
        bus0.req_last  = 4'b0;
        bus0.req_data  = 32'h0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        byte_q_t q0, q1, q2, q3;
        int exp_order [8] = '{0, 1, 2, 3, 0, 3, 0, 3};
        q0 = {8'h10}; q1 = {8'h11}; q2 = {8'h12}; q3 = {8'h13};
        order_q.delete();
        fork
            begin send_msg(0, q0, 0, 0); send_msg(0, q0, 0, 0); send_msg(0, q0, 0, 0); end
            send_msg(1, q1, 0, 0);
            send_msg(2, q2, 0, 0);
            begin send_msg(3, q3, 0, 0); send_msg(3, q3, 0, 0); send_msg(3, q3, 0, 0); end
        join
        wait_quiet();
        checks++;
        if (order_q.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d messages, required 8", order_q.size());
        end
        for (int k = 0; k < 8 && k < order_q.size(); k++) begin
            checks++;
            if (order_q[k] != exp_order[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got requester %0d, required %0d", k, order_q[k], exp_order[k]);
            end
        end
    endtask

    task automatic test_single();
        byte_q_t q, q1;
        int f, c, base;
        q  = {8'h41, 8'h42, 8'h43};
        q1 = {8'h44};
        base = start_cnt0;
        send_msg(2, q, 0, 0);
        checks++;
        if (grant0 !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b, required 0100", grant0); end
        c = 0;
        while (grant0 !== 4'b0 && c < TMO) begin @(negedge clk); c++; end
        f = fall0_cyc;
        checks++;
        if (grant0 !== 4'b0 || cyc != f + 1) begin
            errors++;
            $display("FAIL single_release: grant=%b at cycle %0d, required 0000 at cycle %0d", grant0, cyc, f + 1);
        end
        send_msg(0, q1, 0, 0);
        checks++;
        if (grant_rise_cyc - f != GAP + 2) begin
            errors++;
            $display("FAIL single_gap: next grant %0d cycles after busy fall, required %0d", grant_rise_cyc - f, GAP + 2);
        end
        wait_quiet();
        checks++;
        if (start_cnt0 - base != 4) begin
            errors++;
            $display("FAIL single_starts: got %0d start pulses, required 4", start_cnt0 - base);
        end
    endtask

    task automatic test_no_interleave();
        byte_q_t q1, q0;
        int exp_order [5] = '{1, 1, 1, 1, 0};
        int g0, g1;
        bit seen1;
        logic bad;
        q1 = {8'h30, 8'h31, 8'h32, 8'h33};
        q0 = {8'h38};
        order_q.delete();
        g0 = -1; g1 = -1; seen1 = 0; bad = 1'b0;
        fork
            send_msg(1, q1, 2, 20);
            send_msg(0, q0, 0, 0);
            begin
                for (int c = 0; c < 4 * TMO && g1 < 0; c++) begin
                    @(negedge clk);
                    #1;
                    if (grant0 !== 4'b0001 && bus0.req_ready[0] !== 1'b0) bad = 1'b1;
                    if (grant0 === 4'b0010) seen1 = 1;
                    if (grant0 === 4'b0 && seen1 && g0 < 0) g0 = cyc;
                    if (grant0 === 4'b0001 && g1 < 0) g1 = cyc;
                end
            end
        join
        wait_quiet();
        checks++;
        if (bad) begin errors++; $display("FAIL ni_ready0: req_ready[0] high without grant, required 0"); end
        checks++;
        if (g0 < 0 || g1 - g0 != GAP + 1) begin
            errors++;
            $display("FAIL ni_gap: grant0 at %0d release at %0d, required distance %0d", g1, g0, GAP + 1);
        end
        checks++;
        if (order_q.size() != 5) begin
            errors++;
            $display("FAIL ni_count: got %0d bytes, required 5", order_q.size());
        end
        for (int k = 0; k < 5 && k < order_q.size(); k++) begin
            checks++;
            if (order_q[k] != exp_order[k]) begin
                errors++;
                $display("FAIL ni_order[%0d]: got requester %0d, required %0d", k, order_q[k], exp_order[k]);
            end
        end
    endtask

    task automatic test_busy_entry();
        exp_t e;
        logic bad;
        @(negedge clk);
        ext_busy0 = 1'b1;
        bus0.req_data[15:8] = 8'h5A;
        bus0.req_last[1]    = 1'b1;
        bus0.req_valid[1]   = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (bus0.req_ready[1] !== 1'b0 || grant0 !== 4'b0010) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL busy_hold: ready=%b grant=%b, required ready 0 with grant 0010", bus0.req_ready, grant0); end
        @(negedge clk);
        ext_busy0 = 1'b0;
        #1;
        checks++;
        if (bus0.req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL busy_release: ready[1]=%b, required 1", bus0.req_ready[1]);
        end else begin
            e.idx = 1; e.data = 8'h5A; e.cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        bus0.req_valid[1] = 1'b0;
        bus0.req_last[1]  = 1'b0;
        checks++;
        if (uart_start0 !== 1'b1 || uart_data0 !== 8'h5A) begin
            errors++;
            $display("FAIL busy_start: start=%b data=%h, required start=1 data=5a", uart_start0, uart_data0);
        end
        wait_quiet();
    endtask

    task automatic test_reset_mid();
        byte_q_t q, qa, qb;
        int base;
        logic bad;
        q  = {8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
        qa = {8'h70};
        qb = {8'h72};
        base = start_cnt0;
        abort = 0;
        fork
            send_msg(1, q, 0, 0);
            begin
                for (int c = 0; c < TMO && start_cnt0 < base + 2; c++) @(negedge clk);
                checks++;
                if (start_cnt0 != base + 2) begin
                    errors++;
                    $display("FAIL rmid_progress: got %0d starts, required 2", start_cnt0 - base);
                end
                repeat (3) @(negedge clk);
                #2;
                abort   = 1;
                reset_n = 1'b0;
                sb.delete();
                #1;
                checks++;
                if (grant0 !== 4'b0 || uart_start0 !== 1'b0 || bus0.req_ready !== 4'b0 || uart_data0 !== 8'h00) begin
                    errors++;
                    $display("FAIL rmid_async: grant=%b start=%b ready=%b data=%h, required all zero",
                             grant0, uart_start0, bus0.req_ready, uart_data0);
                end
                repeat (2) @(negedge clk);
            end
        join
        reset_n = 1'b1;
        abort   = 0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (uart_start0 !== 1'b0 || grant0 !== 4'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rmid_stale: start or grant active after release, required idle"); end
        for (int c = 0; c < TMO && uart_busy0 !== 1'b0; c++) @(negedge clk);
        order_q.delete();
        fork
            send_msg(0, qa, 0, 0);
            send_msg(2, qb, 0, 0);
        join
        wait_quiet();
        checks++;
        if (order_q.size() != 2 || order_q[0] != 0) begin
            errors++;
            $display("FAIL rmid_ptr: first served %0d of %0d, required requester 0 of 2",
                     (order_q.size() > 0) ? order_q[0] : -1, order_q.size());
        end
    endtask

    task automatic test_zero_gap();
        int g_dist, n_start;
        logic [7:0] d0, d1;
        logic [3:0] drop;
        g_dist = -1; n_start = 0; d0 = 8'h00; d1 = 8'h00;
        @(negedge clk);
        bus1.req_data  = 32'h0000_2120;
        bus1.req_last  = 4'b0011;
        bus1.req_valid = 4'b0011;
        for (int c = 0; c < TMO && (n_start < 2 || g_dist < 0); c++) begin
            #1;
            drop = bus1.req_valid & bus1.req_ready;
            @(negedge clk);
            bus1.req_valid = bus1.req_valid & ~drop;
            if (uart_start1 === 1'b1) begin
                if (n_start == 0) d0 = uart_data1;
                if (n_start == 1) d1 = uart_data1;
                n_start++;
            end
            if (grant1 === 4'b0010 && g_dist < 0) g_dist = cyc - fall1_cyc;
        end
        bus1.req_valid = 4'b0;
        bus1.req_last  = 4'b0;
        checks++;
        if (n_start != 2 || d0 !== 8'h20 || d1 !== 8'h21) begin
            errors++;
            $display("FAIL zg_bytes: %0d starts data %h %h, required 2 starts data 20 21", n_start, d0, d1);
        end
        checks++;
        if (g_dist != 2) begin
            errors++;
            $display("FAIL zg_timing: grant 0010 %0d cycles after busy fall, required 2", g_dist);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        ext_busy0      = 1'b0;
        bus0.req_valid = 4'b0;
        bus0.req_last  = 4'b0;
        bus0.req_data  = 32'h0;
        bus1.req_valid = 4'b0;
        bus1.req_last  = 4'b0;
        bus1.req_data  = 32'h0;
        test_reset();
        test_fairness();
        test_single();
        test_no_interleave();
        test_busy_entry();
        test_reset_mid();
        test_zero_gap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d accepted bytes never started, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
